// File: rtl/seq_mult_radix.sv
// Sequential radix-2^R unsigned multiplier: N x N -> 2N product, N/R step cycles per operation.
// Optional multiply-accumulate mode when SEQ_MULT_MAC_EN is defined (adds the accum port).
module seq_mult_radix #(
  parameter int N = 256,
  parameter int R = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           abort,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
`ifdef SEQ_MULT_MAC_EN
  input  logic           accum,
`endif
  output logic [2*N-1:0] prod,
  output logic           busy,
  output logic           data_rdy
);

  localparam int W     = 2 * N;
  localparam int STEPS = N / R;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  generate
    if (!(R == 1 || R == 2 || R == 4 || R == 8) || (N % R) != 0 || N < 8) begin : g_bad_param
      $fatal(1, "seq_mult_radix: illegal parameters N=%0d R=%0d", N, R);
    end
  endgenerate

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_r, state_next_s;
  logic [W-1:0]    a_sh_r;
  logic [N-1:0]    b_sh_r;
  logic [W-1:0]    acc_r;
  logic [CW-1:0]   cnt_r;
  logic [W-1:0]    prod_r;
  logic            busy_r;
  logic            data_rdy_r;
  logic            accept_s;
  logic            done_s;
  logic [W-1:0]    pp_s;
  logic [W-1:0]    sum_s;
  logic [W-1:0]    acc_init_s;

  // Partial product of the shifted multiplicand and the current multiplier digit, plus running sum.
  always_comb begin
    pp_s  = a_sh_r * W'(b_sh_r[R-1:0]);
    sum_s = acc_r + pp_s;
  end

  // Accumulator seed for a newly accepted operation.
  always_comb begin
    acc_init_s = {W{1'b0}};
`ifdef SEQ_MULT_MAC_EN
    // On back-to-back issue the seed is the result completing on this same edge.
    if (accum) begin
      acc_init_s = done_s ? sum_s : prod_r;
    end else begin
      acc_init_s = {W{1'b0}};
    end
`endif
  end

  // Next-state logic: accept, restart, back-to-back and abort handling.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (en && !abort) begin
          accept_s     = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_next_s = IDLE;
        end else if (en) begin
          accept_s     = 1'b1;
          done_s       = (cnt_r == {CW{1'b0}});
          state_next_s = RUN;
        end else if (cnt_r == {CW{1'b0}}) begin
          done_s       = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      a_sh_r     <= {W{1'b0}};
      b_sh_r     <= {N{1'b0}};
      acc_r      <= {W{1'b0}};
      cnt_r      <= {CW{1'b0}};
      prod_r     <= {W{1'b0}};
      busy_r     <= 1'b0;
      data_rdy_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      busy_r     <= (state_next_s == RUN);
      data_rdy_r <= done_s;
      if (done_s) begin
        prod_r <= sum_s;
      end else begin
        prod_r <= prod_r;
      end
      if (accept_s) begin
        a_sh_r <= {{N{1'b0}}, a};
        b_sh_r <= b;
        acc_r  <= acc_init_s;
        cnt_r  <= CNT_LAST;
      end else if (state_r == RUN && !abort) begin
        a_sh_r <= a_sh_r << R;
        b_sh_r <= b_sh_r >> R;
        acc_r  <= sum_s;
        cnt_r  <= cnt_r - CNT_ONE;
      end else begin
        a_sh_r <= a_sh_r;
        b_sh_r <= b_sh_r;
        acc_r  <= acc_r;
        cnt_r  <= cnt_r;
      end
    end
  end

  assign prod     = prod_r;
  assign busy     = busy_r;
  assign data_rdy = data_rdy_r;

endmodule

// File: tb/tb_seq_mult_radix.sv
// Directed bench for seq_mult_radix (N=256, R=4): vector table plus restart/abort/back-to-back/reset sequences.
module tb_seq_mult_radix;
  localparam int N = 256;
  localparam int R = 4;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
`ifdef SEQ_MULT_MAC_EN
  logic         accum = 1'b0;
`endif
  logic [W-1:0] prod;
  logic         busy;
  logic         data_rdy;

  int n_checks = 0;
  int n_fail = 0;

  seq_mult_radix #(.N(N), .R(R)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .abort(abort), .a(a), .b(b),
`ifdef SEQ_MULT_MAC_EN
    .accum(accum),
`endif
    .prod(prod), .busy(busy), .data_rdy(data_rdy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [N-1:0] va;
    logic [N-1:0] vb;
    logic [W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ends at the negedge right after the accepting edge.
  task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb_v);
    @(negedge clk);
    a = ta; b = tb_v; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  // Counts negedge samples (starting with the current one) until data_rdy, bounded.
  task automatic wait_done(output int cyc, output int bcnt);
    bit done;
    cyc = 0; bcnt = 0; done = 1'b0;
    while (!done && cyc < 300) begin
      cyc++;
      if (busy) bcnt++;
      if (data_rdy) done = 1'b1;
      else @(negedge clk);
    end
  endtask

  initial begin
    vec_t vecs[6];
    logic [W-1:0] held;
    int cyc, bcnt, rdy_cnt;

    vecs[0] = '{va: N'(5), vb: N'(12), exp: W'(60)};
    vecs[1] = '{va: {N{1'b1}}, vb: N'(2), exp: {{(N-1){1'b0}}, {N{1'b1}}, 1'b0}};
    vecs[2] = '{va: {4'h8, 252'h0}, vb: N'(2), exp: {{(N-1){1'b0}}, 1'b1, {N{1'b0}}}};
    vecs[3] = '{va: {N{1'b1}}, vb: {N{1'b1}}, exp: {{(N-1){1'b1}}, 1'b0, {(N-1){1'b0}}, 1'b1}};
    vecs[4] = '{va: N'(0), vb: {N{1'b1}}, exp: W'(0)};
    vecs[5] = '{va: N'(3), vb: N'(7), exp: W'(21)};

    #5;
    check("reset_prod", prod, W'(0));
    check("reset_busy", W'(busy), W'(0));
    check("reset_rdy", W'(data_rdy), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].va, vecs[i].vb);
      wait_done(cyc, bcnt);
      check($sformatf("vec%0d_latency", i), W'(cyc), W'(65));
      check($sformatf("vec%0d_busy", i), W'(bcnt), W'(64));
      check($sformatf("vec%0d_prod", i), prod, vecs[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d_rdy_pulse", i), W'(data_rdy), W'(0));
    end

    // Restart at step 20: only the second op completes.
    held = prod;
    issue({8{32'hDEADBEEF}}, {N{1'b1}});
    rdy_cnt = 0;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      if (data_rdy) rdy_cnt++;
    end
    check("restart_prod_held", prod, held);
    a = N'(3); b = N'(7); en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_done(cyc, bcnt);
    check("restart_no_early_rdy", W'(rdy_cnt), W'(0));
    check("restart_latency", W'(cyc), W'(65));
    check("restart_prod", prod, W'(21));

    // Abort at step 30.
    issue(N'(5), N'(12));
    repeat (29) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_drop", W'(busy), W'(0));
    rdy_cnt = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (data_rdy) rdy_cnt++;
    end
    check("abort_no_rdy", W'(rdy_cnt), W'(0));
    check("abort_prod_held", prod, W'(21));

    // abort and en together in IDLE: nothing accepted.
    a = N'(9); b = N'(9); en = 1'b1; abort = 1'b1;
    @(negedge clk);
    en = 1'b0; abort = 1'b0;
    check("abort_en_idle_busy", W'(busy), W'(0));
    rdy_cnt = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (data_rdy) rdy_cnt++;
    end
    check("abort_en_idle_no_rdy", W'(rdy_cnt), W'(0));

    // Back-to-back: en on the completing edge.
    issue(N'(5), N'(12));
    repeat (63) @(negedge clk);
    a = N'(2); b = N'(3); en = 1'b1;
`ifdef SEQ_MULT_MAC_EN
    accum = 1'b0;
`endif
    @(negedge clk);
    en = 1'b0;
    check("b2b_first_rdy", W'(data_rdy), W'(1));
    check("b2b_first_prod", prod, W'(60));
    check("b2b_busy_stays", W'(busy), W'(1));
    @(negedge clk);
    wait_done(cyc, bcnt);
    check("b2b_second_latency", W'(cyc), W'(64));
    check("b2b_second_busy", W'(bcnt), W'(63));
    check("b2b_second_prod", prod, W'(6));

`ifdef SEQ_MULT_MAC_EN
    // Accumulate onto a prior result of 60.
    issue(N'(5), N'(12));
    wait_done(cyc, bcnt);
    check("mac_base", prod, W'(60));
    @(negedge clk);
    a = N'(2); b = N'(2); en = 1'b1; accum = 1'b1;
    @(negedge clk);
    en = 1'b0; accum = 1'b0;
    wait_done(cyc, bcnt);
    check("mac_prod", prod, W'(64));
`endif

    // Async reset mid-run, off the clock edge.
    issue(N'(7), N'(7));
    repeat (10) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_prod", prod, W'(0));
    check("async_rst_busy", W'(busy), W'(0));
    check("async_rst_rdy", W'(data_rdy), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
